// File: rtl/arq_frame_rx.sv
// ARQ frame receiver: buffers a frame's payload speculatively, commits it on
// a good CRC (or unconditionally with ARQ disabled), answers with ACK/NACK
// and streams committed bytes out through a registered valid/ready stage.
// Optional build macro ARQ_RX_SEQ_EN: byte 0 of each frame is a header whose
// bit 0 is a sequence number; a good frame repeating the last accepted
// sequence number is ACKed again but not committed.
module arq_frame_rx #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PYLD_LEN = 16,
  parameter int unsigned DEPTH    = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_arq_en,
  input  logic [DATA_W-1:0]      i_frame_data,
  input  logic                   i_frame_valid,
  input  logic                   i_frame_sof,
  output logic [DATA_W-1:0]      o_pyld_data,
  output logic                   o_pyld_valid,
  input  logic                   i_pyld_ready,
  output logic                   o_ack,
  output logic                   o_nack,
  output logic                   o_crc_err,
  output logic [15:0]            o_err_cnt,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = 9;
`ifdef ARQ_RX_SEQ_EN
  localparam int unsigned HDR_LEN = 1;
`else
  localparam int unsigned HDR_LEN = 0;
`endif
  localparam int unsigned FRAME_LEN = HDR_LEN + PYLD_LEN + 1;
  localparam logic [CW-1:0] LAST_PYLD_CNT  = CW'(HDR_LEN + PYLD_LEN - 1);
  localparam logic [CW-1:0] LAST_FRAME_CNT = CW'(FRAME_LEN - 1);
  localparam logic [DATA_W-1:0] CRC_POLY   = DATA_W'(8'h07);

`ifdef ARQ_RX_SEQ_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_HDR = 3'd1, S_PYLD = 3'd2, S_CRC = 3'd3, S_DROP = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PYLD = 3'd2, S_CRC = 3'd3, S_DROP = 3'd4
  } state_t;
`endif

  state_t state_q, state_nxt, start_state;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_nxt;
  logic [PW-1:0] commit_ptr_q, commit_ptr_nxt;
  logic [PW-1:0] rd_ptr_q, rd_ptr_nxt;
  logic [PW-1:0] used_c, free_c;
  logic [PW-1:0] level_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [DATA_W-1:0] crc_q, crc_nxt;
  logic [AW-1:0] wr_addr;
  logic wr_en, err_inc, commit_evt, dup, crc_match;
  logic ack_nxt, nack_nxt, crc_err_nxt;
  logic byte_in, sof_in, pyld_byte, has_space;
  logic load_c, valid_nxt;
`ifdef ARQ_RX_SEQ_EN
  logic seq_q, seq_nxt, last_seq_q;
`endif

  // One MSB-first CRC-8 step over a whole byte
  function automatic logic [DATA_W-1:0] crc8_upd(input logic [DATA_W-1:0] crc,
                                                 input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] c;
    c = crc ^ d;
    for (int b = 0; b < int'(DATA_W); b++) begin
      c = c[DATA_W-1] ? ({c[DATA_W-2:0], 1'b0} ^ CRC_POLY) : {c[DATA_W-2:0], 1'b0};
    end
    return c;
  endfunction

  // Input qualifiers and admission check against committed-but-unread space
  always_comb begin
    byte_in   = i_frame_valid;
    sof_in    = i_frame_valid & i_frame_sof;
`ifdef ARQ_RX_SEQ_EN
    pyld_byte = byte_in & ~i_frame_sof & ((state_q == S_PYLD) | (state_q == S_HDR));
`else
    pyld_byte = byte_in & ~i_frame_sof & (state_q == S_PYLD);
`endif
    used_c    = commit_ptr_q - rd_ptr_q;
    free_c    = PW'(DEPTH) - used_c;
    has_space = (free_c >= PW'(PYLD_LEN));
    crc_match = (i_frame_data == crc_q);
`ifdef ARQ_RX_SEQ_EN
    dup       = (seq_q == last_seq_q);
`else
    dup       = 1'b0;
`endif
  end

  // Target state for a SOF byte
  always_comb begin
    start_state = S_DROP;
    if (has_space) begin
`ifdef ARQ_RX_SEQ_EN
      start_state = S_HDR;
`else
      start_state = (PYLD_LEN == 1) ? S_CRC : S_PYLD;
`endif
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  // FSM next state; a SOF always restarts framing
  always_comb begin
    state_nxt = state_q;
    if (sof_in) begin
      state_nxt = start_state;
    end else if (byte_in) begin
      case (state_q)
        S_IDLE: state_nxt = S_IDLE;
`ifdef ARQ_RX_SEQ_EN
        S_HDR:  state_nxt = (cnt_q == LAST_PYLD_CNT) ? S_CRC : S_PYLD;
`endif
        S_PYLD: state_nxt = (cnt_q == LAST_PYLD_CNT) ? S_CRC : S_PYLD;
        S_CRC:  state_nxt = S_IDLE;
        S_DROP: state_nxt = (cnt_q == LAST_FRAME_CNT) ? S_IDLE : S_DROP;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: buffer writes, pointer moves, CRC and response pulses
  always_comb begin
    wr_ptr_nxt     = wr_ptr_q;
    commit_ptr_nxt = commit_ptr_q;
    cnt_nxt        = cnt_q;
    crc_nxt        = crc_q;
    wr_en          = 1'b0;
    wr_addr        = wr_ptr_q[AW-1:0];
    ack_nxt        = 1'b0;
    nack_nxt       = 1'b0;
    crc_err_nxt    = 1'b0;
    err_inc        = 1'b0;
    commit_evt     = 1'b0;
`ifdef ARQ_RX_SEQ_EN
    seq_nxt        = seq_q;
`endif
    if (sof_in) begin
      // Any frame in flight is abandoned silently
      wr_ptr_nxt = commit_ptr_q;
      cnt_nxt    = CW'(1);
      crc_nxt    = '0;
      if (has_space) begin
`ifdef ARQ_RX_SEQ_EN
        seq_nxt    = i_frame_data[0];
`else
        wr_en      = 1'b1;
        wr_addr    = commit_ptr_q[AW-1:0];
        wr_ptr_nxt = commit_ptr_q + PW'(1);
        crc_nxt    = crc8_upd('0, i_frame_data);
`endif
      end
    end else if (pyld_byte) begin
      wr_en      = 1'b1;
      wr_ptr_nxt = wr_ptr_q + PW'(1);
      crc_nxt    = crc8_upd(crc_q, i_frame_data);
      cnt_nxt    = cnt_q + CW'(1);
    end else if (byte_in && state_q == S_CRC) begin
      cnt_nxt = '0;
      if (!i_arq_en) begin
        commit_ptr_nxt = wr_ptr_q;
        commit_evt     = 1'b1;
        crc_err_nxt    = ~crc_match;
      end else if (crc_match) begin
        ack_nxt = 1'b1;
        if (dup) begin
          wr_ptr_nxt = commit_ptr_q;
        end else begin
          commit_ptr_nxt = wr_ptr_q;
          commit_evt     = 1'b1;
        end
      end else begin
        wr_ptr_nxt  = commit_ptr_q;
        nack_nxt    = 1'b1;
        crc_err_nxt = 1'b1;
        err_inc     = 1'b1;
      end
    end else if (byte_in && state_q == S_DROP) begin
      cnt_nxt = cnt_q + CW'(1);
      if (cnt_q == LAST_FRAME_CNT) begin
        cnt_nxt  = '0;
        nack_nxt = i_arq_en;
        err_inc  = 1'b1;
      end
    end
  end

  // Output stage refill and committed-unread level
  always_comb begin
    load_c     = (~o_pyld_valid | i_pyld_ready) & (rd_ptr_q != commit_ptr_q);
    rd_ptr_nxt = rd_ptr_q + PW'(load_c);
    if (load_c)            valid_nxt = 1'b1;
    else if (i_pyld_ready) valid_nxt = 1'b0;
    else                   valid_nxt = o_pyld_valid;
    level_nxt  = commit_ptr_nxt - rd_ptr_nxt + PW'(valid_nxt);
  end

  // Datapath and response registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      crc_q        <= '0;
      o_ack        <= 1'b0;
      o_nack       <= 1'b0;
      o_crc_err    <= 1'b0;
      o_err_cnt    <= '0;
      o_level      <= '0;
      o_pyld_valid <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_nxt;
      commit_ptr_q <= commit_ptr_nxt;
      rd_ptr_q     <= rd_ptr_nxt;
      cnt_q        <= cnt_nxt;
      crc_q        <= crc_nxt;
      o_ack        <= ack_nxt;
      o_nack       <= nack_nxt;
      o_crc_err    <= crc_err_nxt;
      o_level      <= level_nxt;
      o_pyld_valid <= valid_nxt;
      if (err_inc && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
    end
  end

  // Output data register, loaded from the oldest committed entry
  always_ff @(posedge i_clk) begin
    if (i_rst)       o_pyld_data <= '0;
    else if (load_c) o_pyld_data <= mem[rd_ptr_q[AW-1:0]];
  end

  // Payload buffer write port
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= i_frame_data;
  end

`ifdef ARQ_RX_SEQ_EN
  // Sequence number of the frame in flight and of the last committed frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      seq_q      <= 1'b0;
      last_seq_q <= 1'b1;
    end else begin
      seq_q <= seq_nxt;
      if (commit_evt) last_seq_q <= seq_q;
    end
  end
`endif

endmodule

// File: tb/tb_arq_frame_rx.sv
// Testbench for arq_frame_rx (PYLD_LEN=4, DEPTH=8); honours ARQ_RX_SEQ_EN.
module tb_arq_frame_rx;

  localparam int unsigned PL = 4;
  localparam int unsigned DP = 8;
  localparam int unsigned LW = $clog2(DP) + 1;
`ifdef ARQ_RX_SEQ_EN
  localparam int HL = 1;
`else
  localparam int HL = 0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_arq_en = 1'b1;
  logic [7:0]    i_frame_data = '0;
  logic          i_frame_valid = 1'b0;
  logic          i_frame_sof = 1'b0;
  logic [7:0]    o_pyld_data;
  logic          o_pyld_valid;
  logic          i_pyld_ready;
  logic          o_ack, o_nack, o_crc_err;
  logic [15:0]   o_err_cnt;
  logic [LW-1:0] o_level;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int ack_n = 0, nack_n = 0, cerr_n = 0;
  logic [7:0] pl [PL];

  logic rand_rdy = 1'b0, rdy_fix = 1'b1, rdy_bit = 1'b1;
  assign i_pyld_ready = rand_rdy ? rdy_bit : rdy_fix;

  arq_frame_rx #(.DATA_W(8), .PYLD_LEN(PL), .DEPTH(DP)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_arq_en(i_arq_en),
    .i_frame_data(i_frame_data), .i_frame_valid(i_frame_valid), .i_frame_sof(i_frame_sof),
    .o_pyld_data(o_pyld_data), .o_pyld_valid(o_pyld_valid), .i_pyld_ready(i_pyld_ready),
    .o_ack(o_ack), .o_nack(o_nack), .o_crc_err(o_crc_err),
    .o_err_cnt(o_err_cnt), .o_level(o_level)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    #2;
    rdy_bit = 1'($urandom);
  end

  // Collect transfers and response pulses
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_ack)     ack_n++;
      if (o_nack)    nack_n++;
      if (o_crc_err) cerr_n++;
      if (o_pyld_valid && i_pyld_ready) obs_q.push_back(o_pyld_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // CRC-8 (x^8+x^2+x+1) as bitwise polynomial division of the payload
  function automatic logic [7:0] ref_crc();
    logic [7:0] r = 8'h00;
    logic fb;
    for (int i = 0; i < int'(PL); i++)
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ pl[i][b];
        r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    return r;
  endfunction

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic sof, input logic [7:0] d);
    i_frame_valid = 1'b1;
    i_frame_sof   = sof;
    i_frame_data  = d;
    cycle();
    i_frame_valid = 1'b0;
    i_frame_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic seq, input logic [7:0] cx, input int npl, input bit crc_on);
    logic [7:0] c;
    c = ref_crc() ^ cx;
    if (HL != 0) send_byte(1'b1, {7'd0, seq});
    for (int i = 0; i < npl; i++) send_byte((HL == 0) && (i == 0), pl[i]);
    if (crc_on) send_byte(1'b0, c);
  endtask

  task automatic fill_pl(input bit zero);
    for (int i = 0; i < int'(PL); i++) pl[i] = zero ? 8'h00 : 8'($urandom);
  endtask

  task automatic push_pl();
    for (int i = 0; i < int'(PL); i++) exp_q.push_back(pl[i]);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_frame_valid = 1'b0;
    i_frame_sof = 1'b0;
    i_arq_en = 1'b1;
    rand_rdy = 1'b0;
    rdy_fix = 1'b1;
    repeat (2) cycle();
    obs_q.delete();
    exp_q.delete();
    ack_n = 0; nack_n = 0; cerr_n = 0;
    i_rst = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget);
    int b = 0;
    while (obs_q.size() < n && b < budget) begin
      cycle();
      b++;
    end
    total++;
    if (obs_q.size() != n) begin
      bad++;
      $display("FAIL wait_obs: got %0d bytes want %0d", obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (o_pyld_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", o_pyld_valid); end
    total++; if ({o_ack, o_nack, o_crc_err} !== 3'b000) begin bad++; $display("FAIL rst_pulses: got %b want 000", {o_ack, o_nack, o_crc_err}); end
    total++; if (o_err_cnt !== 16'd0) begin bad++; $display("FAIL rst_err_cnt: got %0d want 0", o_err_cnt); end
    total++; if (o_level !== LW'(0)) begin bad++; $display("FAIL rst_level: got %0d want 0", o_level); end
  endtask

  task automatic test_good_frame();
    do_reset();
    fill_pl(1'b1);
    send_frame(1'b0, 8'h00, PL, 1'b1);
    total++; if (o_ack !== 1'b1) begin bad++; $display("FAIL good_ack_n1: got %b want 1", o_ack); end
    total++; if (o_nack !== 1'b0) begin bad++; $display("FAIL good_nack_n1: got %b want 0", o_nack); end
    total++; if (o_pyld_valid !== 1'b0) begin bad++; $display("FAIL good_valid_n1: got %b want 0", o_pyld_valid); end
    cycle();
    total++; if (o_ack !== 1'b0) begin bad++; $display("FAIL good_ack_n2: got %b want 0", o_ack); end
    for (int k = 0; k < int'(PL); k++) begin
      total++;
      if (o_pyld_valid !== 1'b1 || o_pyld_data !== 8'h00) begin
        bad++; $display("FAIL good_out_n%0d: got v=%b d=%h want v=1 d=00", k + 2, o_pyld_valid, o_pyld_data);
      end
      cycle();
    end
    total++; if (o_pyld_valid !== 1'b0) begin bad++; $display("FAIL good_out_end: got %b want 0", o_pyld_valid); end
  endtask

  task automatic test_bad_crc();
    logic seen = 1'b0;
    do_reset();
    fill_pl(1'b1);
    send_frame(1'b0, 8'h01, PL, 1'b1);
    total++; if ({o_ack, o_nack, o_crc_err} !== 3'b011) begin bad++; $display("FAIL bad_pulses: got %b want 011", {o_ack, o_nack, o_crc_err}); end
    total++; if (o_err_cnt !== 16'd1) begin bad++; $display("FAIL bad_err_cnt: got %0d want 1", o_err_cnt); end
    repeat (8) begin
      if (o_pyld_valid) seen = 1'b1;
      cycle();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL bad_no_output: got %b want 0", seen); end
    total++; if (o_level !== LW'(0)) begin bad++; $display("FAIL bad_level: got %0d want 0", o_level); end
  endtask

  task automatic test_arq_off();
    do_reset();
    i_arq_en = 1'b0;
    fill_pl(1'b0);
    send_frame(1'b0, 8'h5A, PL, 1'b1);
    push_pl();
    total++; if ({o_ack, o_nack, o_crc_err} !== 3'b001) begin bad++; $display("FAIL off_pulses: got %b want 001", {o_ack, o_nack, o_crc_err}); end
    wait_obs(PL, 50);
    for (int i = 0; i < int'(PL); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL off_data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (o_err_cnt !== 16'd0) begin bad++; $display("FAIL off_err_cnt: got %0d want 0", o_err_cnt); end
    total++; if (ack_n != 0 || nack_n != 0) begin bad++; $display("FAIL off_acks: got ack=%0d nack=%0d want 0 0", ack_n, nack_n); end
    i_arq_en = 1'b1;
  endtask

  task automatic test_overflow();
    do_reset();
    rdy_fix = 1'b0;
    fill_pl(1'b0); push_pl(); send_frame(1'b0, 8'h00, PL, 1'b1);
    fill_pl(1'b0); push_pl(); send_frame(1'b1, 8'h00, PL, 1'b1);
    fill_pl(1'b0);            send_frame(1'b0, 8'h00, PL, 1'b1);
    total++; if (o_nack !== 1'b1) begin bad++; $display("FAIL ovf_nack: got %b want 1", o_nack); end
    repeat (3) cycle();
    total++; if (ack_n != 2 || nack_n != 1) begin bad++; $display("FAIL ovf_acks: got ack=%0d nack=%0d want 2 1", ack_n, nack_n); end
    total++; if (o_err_cnt !== 16'd1) begin bad++; $display("FAIL ovf_err_cnt: got %0d want 1", o_err_cnt); end
    total++; if (o_level !== LW'(DP)) begin bad++; $display("FAIL ovf_level: got %0d want %0d", o_level, DP); end
    rdy_fix = 1'b1;
    wait_obs(2 * PL, 50);
    for (int i = 0; i < int'(2 * PL); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    cycle();
    total++; if (o_level !== LW'(0)) begin bad++; $display("FAIL ovf_level_end: got %0d want 0", o_level); end
  endtask

  task automatic test_abort();
    do_reset();
    fill_pl(1'b0);
    send_frame(1'b0, 8'h00, 2, 1'b0);
    fill_pl(1'b0); push_pl();
    send_frame(1'b0, 8'h00, PL, 1'b1);
    wait_obs(PL, 50);
    repeat (3) cycle();
    total++; if (obs_q.size() != int'(PL)) begin bad++; $display("FAIL abort_count: got %0d want %0d", obs_q.size(), PL); end
    for (int i = 0; i < int'(PL); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (ack_n != 1 || nack_n != 0) begin bad++; $display("FAIL abort_acks: got ack=%0d nack=%0d want 1 0", ack_n, nack_n); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rdy_fix = 1'b0;
    fill_pl(1'b0);
    send_frame(1'b0, 8'h00, PL, 1'b1);
    fill_pl(1'b0);
    send_frame(1'b1, 8'h00, 2, 1'b0);
    do_reset();
    total++; if (o_pyld_valid !== 1'b0 || o_level !== LW'(0)) begin bad++; $display("FAIL rstmid_state: got v=%b lvl=%0d want 0 0", o_pyld_valid, o_level); end
    repeat (10) cycle();
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rstmid_output: got %0d bytes want 0", obs_q.size()); end
  endtask

  task automatic test_random();
    int eack = 0, enack = 0, ecerr = 0, eerr = 0, nbad = 0;
    logic last_seq = 1'b1;
    do_reset();
    rand_rdy = 1'b1;
    for (int f = 0; f < 60; f++) begin
      int kind, b;
      logic arq, seq;
      logic [7:0] cx;
      kind = $urandom_range(0, 3);
      arq  = 1'($urandom);
      seq  = 1'($urandom);
      cx   = (kind == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      b = 0;
      while ((exp_q.size() - obs_q.size()) > int'(DP - PL) && b < 200) begin cycle(); b++; end
      total++; if (b >= 200) begin bad++; $display("FAIL rand_space_wait: frame %0d waited %0d cycles", f, b); end
      repeat ($urandom_range(0, 3)) cycle();
      i_arq_en = arq;
      fill_pl(1'b0);
      if (kind == 2) begin
        send_frame(seq, 8'h00, $urandom_range(1, PL), 1'b0);
      end else begin
        if (arq && cx == 8'h00) begin
          eack++;
          if (!(HL != 0 && seq == last_seq)) begin push_pl(); last_seq = seq; end
        end else if (arq) begin
          enack++; ecerr++; eerr++;
        end else begin
          push_pl(); last_seq = seq;
          if (cx != 8'h00) ecerr++;
        end
        send_frame(seq, cx, PL, 1'b1);
      end
    end
    rand_rdy = 1'b0;
    rdy_fix = 1'b1;
    wait_obs(exp_q.size(), 300);
    repeat (3) cycle();
    for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) nbad++;
    total++; if (nbad != 0 || obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_data: got %0d wrong of %0d bytes (%0d seen) want 0 wrong", nbad, exp_q.size(), obs_q.size()); end
    total++; if (ack_n != eack) begin bad++; $display("FAIL rand_ack: got %0d want %0d", ack_n, eack); end
    total++; if (nack_n != enack) begin bad++; $display("FAIL rand_nack: got %0d want %0d", nack_n, enack); end
    total++; if (cerr_n != ecerr) begin bad++; $display("FAIL rand_crc_err: got %0d want %0d", cerr_n, ecerr); end
    total++; if (o_err_cnt !== 16'(eerr)) begin bad++; $display("FAIL rand_err_cnt: got %0d want %0d", o_err_cnt, eerr); end
    total++; if (o_level !== LW'(0)) begin bad++; $display("FAIL rand_level: got %0d want 0", o_level); end
    i_arq_en = 1'b1;
  endtask

`ifdef ARQ_RX_SEQ_EN
  task automatic test_duplicate();
    do_reset();
    fill_pl(1'b0); push_pl();
    send_frame(1'b0, 8'h00, PL, 1'b1);
    repeat (2) cycle();
    send_frame(1'b0, 8'h00, PL, 1'b1);
    repeat (12) cycle();
    total++; if (ack_n != 2) begin bad++; $display("FAIL dup_acks: got %0d want 2", ack_n); end
    total++; if (obs_q.size() != int'(PL)) begin bad++; $display("FAIL dup_count: got %0d want %0d", obs_q.size(), PL); end
    for (int i = 0; i < int'(PL); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL dup_data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_arq_off();
    test_overflow();
    test_abort();
    test_reset_mid();
`ifdef ARQ_RX_SEQ_EN
    test_duplicate();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
